// File: rtl/highlight_pkg.sv
// Shared constants, index-width helper and encodings for the highlight window.
package highlight_pkg;

  localparam int HL_WORD_SIZE      = 8;
  localparam int HL_NUM_BLOCKS     = 4;
  localparam int HL_BLOCK_WORDS    = 4;
  localparam int HL_NUM_LANES      = 2;
  localparam int HL_WORDS_PER_LANE = 2;

  typedef logic [HL_WORD_SIZE-1:0] hl_word_t;

  typedef enum logic {
    HL_SEL_OK  = 1'b0,
    HL_SEL_ERR = 1'b1
  } hl_err_e;

  // Selector width for an index space of n entries; never narrower than one bit.
  function automatic int hl_idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/highlight_pipe_reg.sv
// Generic valid/ready register stage; accepts when empty or when the downstream drains it.
module highlight_pipe_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d,  data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Next-state: load on accept, otherwise hold (including held data on stall)
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end else begin
        data_d = data_q;
      end
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // Stage state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/highlight_window.sv
// Two-stage block/word selector with valid/ready backpressure.
// Optional match compare enabled by defining HIGHLIGHT_MATCH_EN.
module highlight_window
  import highlight_pkg::*;
#(
  parameter int WORD_SIZE      = HL_WORD_SIZE,
  parameter int NUM_BLOCKS     = HL_NUM_BLOCKS,
  parameter int BLOCK_WORDS    = HL_BLOCK_WORDS,
  parameter int NUM_LANES      = HL_NUM_LANES,
  parameter int WORDS_PER_LANE = HL_WORDS_PER_LANE
) (
  input  logic                                                        clk,
  input  logic                                                        rst_n,
  input  logic [NUM_BLOCKS*BLOCK_WORDS*WORD_SIZE-1:0]                 blocks_in,
  input  logic [NUM_LANES*hl_idx_width(NUM_BLOCKS)-1:0]               block_sel_in,
  input  logic [NUM_LANES*WORDS_PER_LANE*hl_idx_width(BLOCK_WORDS)-1:0] word_sel_in,
  input  logic                                                        in_valid,
  output logic                                                        in_ready,
`ifdef HIGHLIGHT_MATCH_EN
  input  logic [WORD_SIZE-1:0]                                        match_word_in,
  output logic [NUM_LANES*WORDS_PER_LANE-1:0]                         match_hit_out,
`endif
  output logic [NUM_LANES*WORDS_PER_LANE*WORD_SIZE-1:0]               words_out,
  output logic [NUM_LANES-1:0]                                        sel_err_out,
  output logic                                                        out_valid,
  input  logic                                                        out_ready
);

  localparam int BIW      = hl_idx_width(NUM_BLOCKS);
  localparam int WIW      = hl_idx_width(BLOCK_WORDS);
  localparam int BLK_BITS = BLOCK_WORDS * WORD_SIZE;
  localparam int NSEL     = NUM_LANES * WORDS_PER_LANE;
`ifdef HIGHLIGHT_MATCH_EN
  localparam int MW = WORD_SIZE;
  localparam int HW = NSEL;
`else
  localparam int MW = 0;
  localparam int HW = 0;
`endif
  localparam int S1_W = NUM_LANES*BLK_BITS + NSEL*WIW + NUM_LANES + MW;
  localparam int S2_W = NSEL*WORD_SIZE + NUM_LANES + HW;

  logic [NUM_LANES*BLK_BITS-1:0]  blk_sel_s;
  logic [NUM_LANES-1:0]           blk_err_s;
  logic [31:0]                    bsel_s;
  logic [S1_W-1:0]                s1_in_s, s1_out_s;
  logic                           s1_valid_s, s2_ready_s;
  logic [NUM_LANES*BLK_BITS-1:0]  s1_blk_s;
  logic [NSEL*WIW-1:0]            s1_wsel_s;
  logic [NUM_LANES-1:0]           s1_err_s;
  logic [NSEL*WORD_SIZE-1:0]      words_s;
  logic [NUM_LANES-1:0]           err_s;
  logic [31:0]                    wsel_s;
  logic                           lane_err_s;
  logic [S2_W-1:0]                s2_in_s, s2_out_s;

  // Stage-1 block mux: matching compare per block, so an out-of-range index yields zeros
  always_comb begin
    blk_sel_s = '0;
    blk_err_s = '0;
    bsel_s    = 32'd0;
    for (int l = 0; l < NUM_LANES; l++) begin
      bsel_s       = 32'(block_sel_in[l*BIW +: BIW]);
      blk_err_s[l] = (bsel_s >= 32'(NUM_BLOCKS)) ? 1'(HL_SEL_ERR) : 1'(HL_SEL_OK);
      for (int b = 0; b < NUM_BLOCKS; b++) begin
        blk_sel_s[l*BLK_BITS +: BLK_BITS] |= (bsel_s == 32'(b)) ?
            blocks_in[b*BLK_BITS +: BLK_BITS] : {BLK_BITS{1'b0}};
      end
    end
  end

`ifdef HIGHLIGHT_MATCH_EN
  logic [WORD_SIZE-1:0] s1_match_s;
  logic [NSEL-1:0]      hit_s;
  assign s1_in_s = {match_word_in, blk_err_s, word_sel_in, blk_sel_s};
  assign {s1_match_s, s1_err_s, s1_wsel_s, s1_blk_s} = s1_out_s;
`else
  assign s1_in_s = {blk_err_s, word_sel_in, blk_sel_s};
  assign {s1_err_s, s1_wsel_s, s1_blk_s} = s1_out_s;
`endif

  highlight_pipe_reg #(.DATA_W(S1_W)) u_stage1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in_s),
    .out_valid (s1_valid_s),
    .out_ready (s2_ready_s),
    .out_data  (s1_out_s)
  );

  // Stage-2 word mux and per-lane error merge
  always_comb begin
    words_s    = '0;
    err_s      = '0;
    wsel_s     = 32'd0;
    lane_err_s = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_err_s = s1_err_s[l];
      for (int k = 0; k < WORDS_PER_LANE; k++) begin
        wsel_s     = 32'(s1_wsel_s[(l*WORDS_PER_LANE+k)*WIW +: WIW]);
        lane_err_s = lane_err_s | (wsel_s >= 32'(BLOCK_WORDS));
        for (int w = 0; w < BLOCK_WORDS; w++) begin
          words_s[(l*WORDS_PER_LANE+k)*WORD_SIZE +: WORD_SIZE] |= (wsel_s == 32'(w)) ?
              s1_blk_s[(l*BLOCK_WORDS+w)*WORD_SIZE +: WORD_SIZE] : {WORD_SIZE{1'b0}};
        end
      end
      err_s[l] = lane_err_s;
    end
  end

`ifdef HIGHLIGHT_MATCH_EN
  // Match compare is suppressed on any lane flagged in error
  always_comb begin
    hit_s = '0;
    for (int i = 0; i < NSEL; i++) begin
      hit_s[i] = (words_s[i*WORD_SIZE +: WORD_SIZE] == s1_match_s) && !err_s[i/WORDS_PER_LANE];
    end
  end
  assign s2_in_s = {hit_s, err_s, words_s};
  assign {match_hit_out, sel_err_out, words_out} = s2_out_s;
`else
  assign s2_in_s = {err_s, words_s};
  assign {sel_err_out, words_out} = s2_out_s;
`endif

  highlight_pipe_reg #(.DATA_W(S2_W)) u_stage2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid_s),
    .in_ready  (s2_ready_s),
    .in_data   (s2_in_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_out_s)
  );

endmodule
